// File: rtl/gfx_fragment_writer.sv
// Pixel sink: clips one rasterizer pixel against the render target and clip
// rectangle, then issues a single Wishbone classic write with depth-based lanes.
module gfx_fragment_writer #(
  parameter int unsigned point_width = 16,
  parameter int unsigned addr_width  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   write_i,
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  input  logic [31:0]            color_i,
  input  logic [1:0]             color_depth_i,
  input  logic [addr_width-1:0]  target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic                   clipping_enable_i,
  input  logic [point_width-1:0] clip_ul_x_i,
  input  logic [point_width-1:0] clip_ul_y_i,
  input  logic [point_width-1:0] clip_lr_x_i,
  input  logic [point_width-1:0] clip_lr_y_i,
  output logic                   ack_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [31:0]            written_count_o,
  output logic [31:0]            discarded_count_o,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [addr_width-1:0]  m_adr_o,
  output logic [3:0]             m_sel_o,
  output logic [31:0]            m_dat_o,
  input  logic                   m_ack_i,
  input  logic                   m_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_DISCARD, ST_ADDR, ST_BUS} state_e;

  state_e                 state_q, state_d;
  logic [point_width-1:0] x_q, x_d, y_q, y_d, size_x_q, size_x_d;
  logic [31:0]            color_q, color_d;
  logic [1:0]             depth_q, depth_d;
  logic [addr_width-1:0]  base_q, base_d, adr_q, adr_d;
  logic                   cyc_q, cyc_d;
  logic [3:0]             sel_q, sel_d;
  logic [31:0]            dat_q, dat_d;
  logic                   ack_q, ack_d, err_q, err_d;
  logic [31:0]            written_q, written_d, discarded_q, discarded_d;

  logic                     discard;
  logic [2*point_width-1:0] offset;
  logic [1:0]               shift;
  logic [addr_width-1:0]    byte_addr;
  logic [3:0]               lane_sel;
  logic [31:0]              lane_dat;

  // Clip test runs on live inputs: only the acceptance edge matters.
  always_comb begin
    discard = (x_i >= target_size_x_i) || (y_i >= target_size_y_i) ||
              (clipping_enable_i && ((x_i < clip_ul_x_i) || (x_i >= clip_lr_x_i) ||
                                     (y_i < clip_ul_y_i) || (y_i >= clip_lr_y_i)));
  end

  // Address and lane generation work only from the latched pixel.
  always_comb begin
    offset = ({{point_width{1'b0}}, y_q} * {{point_width{1'b0}}, size_x_q}) +
             {{point_width{1'b0}}, x_q};
    case (depth_q)
      2'b00:   shift = 2'd0;
      2'b01:   shift = 2'd1;
      default: shift = 2'd2;
    endcase
    byte_addr = base_q + (addr_width'(offset) << shift);
    case (depth_q)
      2'b00: begin
        lane_sel = 4'b0001 << byte_addr[1:0];
        lane_dat = {4{color_q[7:0]}};
      end
      2'b01: begin
        lane_sel = byte_addr[1] ? 4'b1100 : 4'b0011;
        lane_dat = {2{color_q[15:0]}};
      end
      default: begin
        lane_sel = 4'b1111;
        lane_dat = color_q;
      end
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a default first, so no branch can infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    size_x_d    = size_x_q;
    color_d     = color_q;
    depth_d     = depth_q;
    base_d      = base_q;
    adr_d       = adr_q;
    cyc_d       = cyc_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    written_d   = written_q;
    discarded_d = discarded_q;

    case (state_q)
      ST_IDLE: begin
        if (write_i) begin
          x_d      = x_i;
          y_d      = y_i;
          color_d  = color_i;
          depth_d  = color_depth_i;
          base_d   = target_base_i;
          size_x_d = target_size_x_i;
          state_d  = discard ? ST_DISCARD : ST_ADDR;
        end
      end
      ST_DISCARD: begin
        ack_d       = 1'b1;
        discarded_d = discarded_q + 32'd1;
        state_d     = ST_IDLE;
      end
      ST_ADDR: begin
        adr_d   = {byte_addr[addr_width-1:2], 2'b00};
        sel_d   = lane_sel;
        dat_d   = lane_dat;
        cyc_d   = 1'b1;
        state_d = ST_BUS;
      end
      ST_BUS: begin
        // An error response takes priority over a simultaneous ack.
        if (m_err_i || m_ack_i) begin
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = m_err_i;
          state_d = ST_IDLE;
          if (!m_err_i) written_d = written_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      size_x_q    <= '0;
      color_q     <= '0;
      depth_q     <= '0;
      base_q      <= '0;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      written_q   <= '0;
      discarded_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      size_x_q    <= size_x_d;
      color_q     <= color_d;
      depth_q     <= depth_d;
      base_q      <= base_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      written_q   <= written_d;
      discarded_q <= discarded_d;
    end
  end

  assign ack_o             = ack_q;
  assign err_o             = err_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign written_count_o   = written_q;
  assign discarded_count_o = discarded_q;
  assign m_cyc_o           = cyc_q;
  assign m_stb_o           = cyc_q;
  assign m_we_o            = cyc_q;
  assign m_adr_o           = adr_q;
  assign m_sel_o           = sel_q;
  assign m_dat_o           = dat_q;

endmodule

// File: tb/tb_gfx_fragment_writer.sv
// Directed bench for gfx_fragment_writer: vector table for clip/address/lane
// results plus hand sequences for wait states, bus error, back-to-back and reset.
module tb_gfx_fragment_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        write_i;
  logic [15:0] x_i, y_i;
  logic [31:0] color_i;
  logic [1:0]  color_depth_i;
  logic [31:0] target_base_i;
  logic [15:0] target_size_x_i, target_size_y_i;
  logic        clipping_enable_i;
  logic [15:0] clip_ul_x_i, clip_ul_y_i, clip_lr_x_i, clip_lr_y_i;
  logic        ack_o, busy_o, err_o;
  logic [31:0] written_count_o, discarded_count_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_o;
  logic        m_ack_i, m_err_i;

  gfx_fragment_writer #(.point_width(16), .addr_width(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .x_i(x_i), .y_i(y_i),
    .color_i(color_i), .color_depth_i(color_depth_i), .target_base_i(target_base_i),
    .target_size_x_i(target_size_x_i), .target_size_y_i(target_size_y_i),
    .clipping_enable_i(clipping_enable_i), .clip_ul_x_i(clip_ul_x_i),
    .clip_ul_y_i(clip_ul_y_i), .clip_lr_x_i(clip_lr_x_i), .clip_lr_y_i(clip_lr_y_i),
    .ack_o(ack_o), .busy_o(busy_o), .err_o(err_o),
    .written_count_o(written_count_o), .discarded_count_o(discarded_count_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Wishbone slave: responds after wait_states cycles of cyc, ack or err.
  int   wait_states = 0;
  int   wait_cnt    = 0;
  logic slave_err   = 1'b0;
  logic resp;
  always @(posedge clk_i) begin
    if (!m_cyc_o || m_ack_i || m_err_i) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
  end
  assign resp    = m_cyc_o && m_stb_o && (wait_cnt >= wait_states);
  assign m_ack_i = resp && !slave_err;
  assign m_err_i = resp && slave_err;

  typedef struct {
    logic [1:0]  depth;
    logic [31:0] base;
    logic [15:0] sx, sy, x, y;
    logic [31:0] color;
    logic        clip_en;
    logic [15:0] ulx, uly, lrx, lry;
    logic        disc;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  int errors = 0;
  int checks = 0;
  int exp_wr = 0;
  int exp_disc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    color_depth_i     = v.depth;
    target_base_i     = v.base;
    target_size_x_i   = v.sx;
    target_size_y_i   = v.sy;
    x_i               = v.x;
    y_i               = v.y;
    color_i           = v.color;
    clipping_enable_i = v.clip_en;
    clip_ul_x_i       = v.ulx;
    clip_ul_y_i       = v.uly;
    clip_lr_x_i       = v.lrx;
    clip_lr_y_i       = v.lry;
  endtask

  // Issue one write_i pulse and watch until ack_o; poke>0 injects a second
  // write_i (with altered config) before edge number poke, while busy.
  task automatic run_pixel(input int poke, output int ack_edge, output int cyc_cycles,
                           output logic [31:0] adr, output logic [3:0] sel,
                           output logic [31:0] dat, output logic err_seen,
                           output logic stable, output logic extra);
    ack_edge = -1; cyc_cycles = 0; stable = 1'b1; err_seen = 1'b0;
    adr = '0; sel = '0; dat = '0;
    @(negedge clk_i);
    write_i = 1'b1;
    @(posedge clk_i);
    #1 write_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) begin
        write_i       = 1'b1;
        x_i           = 16'd0;
        y_i           = 16'd0;
        target_base_i = 32'hDEAD0000;
      end
      @(posedge clk_i);
      #1 write_i = 1'b0;
      if (m_cyc_o) begin
        if (cyc_cycles == 0) begin
          adr = m_adr_o; sel = m_sel_o; dat = m_dat_o;
          if (!(m_stb_o && m_we_o)) stable = 1'b0;
        end else if ({m_adr_o, m_sel_o, m_dat_o, m_stb_o, m_we_o} != {adr, sel, dat, 2'b11}) begin
          stable = 1'b0;
        end
        cyc_cycles++;
      end
      if (ack_o) begin
        ack_edge = k;
        err_seen = err_o;
        break;
      end
    end
    @(posedge clk_i);
    #1 extra = ack_o | err_o;
  endtask

  int          ae, cc, k2;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        es, st, ex, idle_bad;

  initial begin
    vecs[0]  = '{2'b01, 32'h1000, 16'd640, 16'd480, 16'd3, 16'd2, 32'h0000BEEF, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h00001A04, 4'b1100, 32'hBEEFBEEF};
    vecs[1]  = '{2'b00, 32'h2000, 16'd640, 16'd480, 16'd5, 16'd0, 32'h1234565A, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h00002004, 4'b0010, 32'h5A5A5A5A};
    vecs[2]  = '{2'b10, 32'h0, 16'd640, 16'd480, 16'd9, 16'd15, 32'hCAFEF00D, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[3]  = '{2'b10, 32'h0, 16'd640, 16'd480, 16'd20, 16'd15, 32'hCAFEF00D, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[4]  = '{2'b10, 32'h0, 16'd640, 16'd480, 16'd15, 16'd15, 32'hCAFEF00D, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 1'b0, 32'h0000963C, 4'b1111, 32'hCAFEF00D};
    vecs[5]  = '{2'b00, 32'h0, 16'd640, 16'd480, 16'd10, 16'd10, 32'h00000077, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 1'b0, 32'h00001908, 4'b0100, 32'h77777777};
    vecs[6]  = '{2'b00, 32'h0, 16'd640, 16'd480, 16'd15, 16'd20, 32'h00000077, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[7]  = '{2'b00, 32'h0, 16'd640, 16'd480, 16'd15, 16'd9, 32'h00000077, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[8]  = '{2'b00, 32'h0, 16'd640, 16'd480, 16'd640, 16'd0, 32'h00000011, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[9]  = '{2'b00, 32'h0, 16'd640, 16'd480, 16'd0, 16'd480, 32'h00000011, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[10] = '{2'b00, 32'h0, 16'd640, 16'd480, 16'd639, 16'd479, 32'h000000AB, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h0004AFFC, 4'b1000, 32'hABABABAB};
    vecs[11] = '{2'b11, 32'h100, 16'd4, 16'd4, 16'd2, 16'd3, 32'h0BADBEEF, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h00000138, 4'b1111, 32'h0BADBEEF};
    vecs[12] = '{2'b01, 32'h10, 16'd10, 16'd10, 16'd4, 16'd1, 32'hFFFF1234, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h0000002C, 4'b0011, 32'h12341234};
    vecs[13] = '{2'b10, 32'hFFFFFFF0, 16'd4, 16'd4, 16'd0, 16'd1, 32'h600DF00D, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h00000000, 4'b1111, 32'h600DF00D};

    rst_i   = 1'b1;
    write_i = 1'b0;
    apply(vecs[0]);
    #1;
    check("reset_ctrl", 32'({ack_o, busy_o, err_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}), 32'd0);
    check("reset_adr", m_adr_o, 32'd0);
    check("reset_dat", m_dat_o, 32'd0);
    check("reset_counts", written_count_o | discarded_count_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      run_pixel(0, ae, cc, adr, sel, dat, es, st, ex);
      if (vecs[i].disc) begin
        exp_disc++;
        check($sformatf("v%0d_ack_latency", i), ae, 32'd1);
        check($sformatf("v%0d_no_cyc", i), cc, 32'd0);
      end else begin
        exp_wr++;
        check($sformatf("v%0d_ack_latency", i), ae, 32'd2);
        check($sformatf("v%0d_cyc_cycles", i), cc, 32'd1);
        check($sformatf("v%0d_adr", i), adr, vecs[i].adr);
        check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
        check($sformatf("v%0d_dat", i), dat, vecs[i].dat);
        check($sformatf("v%0d_bus_ctrl", i), 32'(st), 32'd1);
        check($sformatf("v%0d_err", i), 32'(es), 32'd0);
      end
      check($sformatf("v%0d_single_ack", i), 32'(ex), 32'd0);
      check($sformatf("v%0d_written", i), written_count_o, exp_wr);
      check($sformatf("v%0d_discarded", i), discarded_count_o, exp_disc);
    end

    // Wait states, with a busy-time write_i and config change that must be ignored.
    apply('{2'b10, 32'h0, 16'd4, 16'd4, 16'd1, 16'd1, 32'h12345678, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 32'h14, 4'b1111, 32'h12345678});
    wait_states = 3;
    run_pixel(2, ae, cc, adr, sel, dat, es, st, ex);
    exp_wr++;
    check("ws_ack_latency", ae, 32'd5);
    check("ws_cyc_cycles", cc, 32'd4);
    check("ws_adr", adr, 32'h14);
    check("ws_sel", 32'(sel), 32'hF);
    check("ws_dat", dat, 32'h12345678);
    check("ws_bus_stable", 32'(st), 32'd1);
    check("ws_single_ack", 32'(ex), 32'd0);
    idle_bad = 1'b0;
    repeat (4) begin
      @(posedge clk_i);
      #1 idle_bad = idle_bad | m_cyc_o | ack_o | busy_o;
    end
    check("ws_busy_write_ignored", 32'(idle_bad), 32'd0);
    check("ws_written", written_count_o, exp_wr);
    wait_states = 0;

    // Bus error: err_o with ack_o, no counter change.
    apply(vecs[0]);
    slave_err = 1'b1;
    run_pixel(0, ae, cc, adr, sel, dat, es, st, ex);
    slave_err = 1'b0;
    check("err_ack_latency", ae, 32'd2);
    check("err_flag", 32'(es), 32'd1);
    check("err_single_pulse", 32'(ex), 32'd0);
    check("err_written", written_count_o, exp_wr);
    check("err_discarded", discarded_count_o, exp_disc);

    // Back-to-back: write_i held through the discard ack is accepted once IDLE.
    apply(vecs[8]);
    @(negedge clk_i);
    write_i = 1'b1;
    @(posedge clk_i);
    #1 x_i = 16'd1;
    @(posedge clk_i);
    #1 check("b2b_first_ack", 32'({ack_o, busy_o}), 32'b10);
    @(posedge clk_i);
    #1 write_i = 1'b0;
    check("b2b_accepted", 32'({busy_o, ack_o}), 32'b10);
    k2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i);
      #1;
      if (ack_o) begin
        k2 = k;
        break;
      end
    end
    exp_disc++;
    exp_wr++;
    check("b2b_second_ack", k2, 32'd2);
    check("b2b_written", written_count_o, exp_wr);
    check("b2b_discarded", discarded_count_o, exp_disc);

    // Reset in the middle of a bus cycle.
    apply(vecs[0]);
    wait_states = 10;
    @(negedge clk_i);
    write_i = 1'b1;
    @(posedge clk_i);
    #1 write_i = 1'b0;
    @(posedge clk_i);
    #1 check("rst_cyc_before", 32'(m_cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_drop", 32'({m_cyc_o, m_stb_o, m_we_o, ack_o, busy_o}), 32'd0);
    check("rst_counts", written_count_o | discarded_count_o, 32'd0);
    exp_wr = 0;
    exp_disc = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_states = 0;
    run_pixel(0, ae, cc, adr, sel, dat, es, st, ex);
    exp_wr++;
    check("post_rst_ack_latency", ae, 32'd2);
    check("post_rst_adr", adr, 32'h1A04);
    check("post_rst_written", written_count_o, exp_wr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gfx_fragment_writer.md
Name: gfx_fragment_writer

Overview:
- Pixel sink for the rasterizer. Accepts one pixel write request (write_i pulse, x/y, colour) at a time and clips it against the render target and the clip rectangle.
- Surviving pixels become a single Wishbone classic write into the framebuffer, with byte lanes set by colour depth. ack_o is returned once the pixel is written or discarded.
- Sits between the rasterizer's pixel write/ack handshake and the memory arbiter's master port.

Parameters:
- point_width, 16, width of pixel coordinates and target/clip dimensions (unsigned)
- addr_width, 32, framebuffer byte address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- write_i  in  1  one-cycle pixel write request
- x_i  in  point_width  pixel x (unsigned)
- y_i  in  point_width  pixel y (unsigned)
- color_i  in  32  pixel colour, LSB-aligned
- color_depth_i  in  2  00=8bpp, 01=16bpp, 10=32bpp, 11 treated as 32bpp
- target_base_i  in  addr_width  framebuffer byte base address
- target_size_x_i  in  point_width  target width in pixels
- target_size_y_i  in  point_width  target height in pixels
- clipping_enable_i  in  1  enable clip-rectangle test
- clip_ul_x_i, clip_ul_y_i  in  point_width each  clip upper-left, inclusive
- clip_lr_x_i, clip_lr_y_i  in  point_width each  clip lower-right, exclusive
- ack_o  out  1  one-cycle completion pulse to the rasterizer
- busy_o  out  1  high whenever state != IDLE
- err_o  out  1  one-cycle pulse, coincident with ack_o, when the bus returned m_err_i
- written_count_o  out  32  pixels written since reset (wraps)
- discarded_count_o  out  32  pixels clipped since reset (wraps)
- m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone master controls
- m_adr_o  out  addr_width  word-aligned address, bits [1:0] always 0
- m_sel_o  out  4  byte selects
- m_dat_o  out  32  write data
- m_ack_i, m_err_i  in  1 each  Wishbone slave responses

Behaviour:
- Reset: rst_i is asynchronous, active-high. Clock is clk_i. On reset all outputs, counters and latched registers go to 0 and the state goes to IDLE. Asserting reset during a bus cycle drops cyc/stb immediately and the pixel is lost (no ack_o).
- States: IDLE, DISCARD, ADDR, BUS.
- IDLE:
  - On write_i, latch x, y, colour, depth, base and size_x.
  - Evaluate clip using unsigned compares. The pixel is discarded if x>=target_size_x_i, or y>=target_size_y_i, or (clipping_enable_i and (x<clip_ul_x_i or x>=clip_lr_x_i or y<clip_ul_y_i or y>=clip_lr_y_i)).
  - Discard goes to DISCARD; otherwise go to ADDR.
- DISCARD: ack_o<=1 for one cycle, discarded_count_o+=1, go to IDLE.
- ADDR:
  - offset = y*size_x + x, 2*point_width bits, unsigned.
  - byte_addr = base + (offset << shift), where shift = 0/1/2 for 8/16/32bpp; result truncated to addr_width.
  - m_adr_o <= byte_addr with [1:0] forced to 0. Assert m_cyc_o=m_stb_o=m_we_o=1. Go to BUS.
- Lanes: byte k is data[8k+7:8k] (little-endian).
  - 8bpp: m_sel_o = 4'b0001 << byte_addr[1:0]; m_dat_o = {4{color[7:0]}}.
  - 16bpp: m_sel_o = byte_addr[1] ? 4'b1100 : 4'b0011; m_dat_o = {2{color[15:0]}}.
  - 32bpp: m_sel_o = 4'b1111; m_dat_o = color.
- BUS:
  - Hold all bus outputs stable until m_ack_i or m_err_i is sampled high.
  - On that edge, cyc/stb/we go to 0, ack_o<=1 for one cycle, and the state returns to IDLE.
  - On ack, written_count_o+=1. On err, err_o<=1 and no counter changes. If both are high, err wins.
- Latency (write_i sampled at edge T0):
  - Discarded pixel: ack_o high in the cycle after edge T1.
  - Written pixel: cyc visible after T1. With a zero-wait slave, m_ack_i is sampled at T2 and ack_o is high after T2.
- Requests while busy: write_i while busy_o=1 is ignored (protocol violation; no latching). A write_i in the same cycle ack_o is high is accepted, because the state is already IDLE.
- Config inputs matter only at the acceptance edge. Later changes do not affect an in-flight pixel.
- Counters wrap from 0xFFFFFFFF to 0.

Test Plan:
- base=0x1000, size_x=640, size_y=480, depth=01, x=3, y=2, color=0xBEEF, zero-wait slave -> m_adr_o=0x1A04, m_sel_o=1100, m_dat_o=0xBEEFBEEF; ack_o pulses 3 edges after write_i; written_count_o=1.
- base=0x2000, depth=00, x=5, y=0, color=0x5A -> m_adr_o=0x2004, m_sel_o=0010, m_dat_o=0x5A5A5A5A.
- base=0, depth=10, size_x=4, x=1, y=1, color=0x12345678; slave inserts 3 wait states -> m_adr_o=0x14, m_sel_o=1111; cyc held 4 cycles; single ack_o pulse.
- clipping_enable=1, clip 10..20 x 10..20, pixels (9,15), (20,15), (15,15) -> first two ack one cycle after DISCARD with no cyc; third written; discarded_count_o=2, written_count_o=1.
- x=640 with size_x=640 and clipping disabled -> discarded; slave returns m_err_i on a valid pixel -> err_o and ack_o pulse together, written_count_o unchanged.
- rst_i asserted while m_cyc_o=1 -> cyc/stb/we/ack_o drop asynchronously; after release, a new write_i completes normally.
